// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {RF_INIT, RF_READY} rf_state_t;

  function automatic int rf_addr_w(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_scrub.sv
// rtl/regfile_mp_scrub.sv - scrub controller: walks indices 1..NREGS-1 after reset or on request
module rf_scrub_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = rf_addr_w(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  output logic          ready_o,
  output logic          scrub_we_o,
  output logic [AW-1:0] scrub_idx_o
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_INIT;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register 0 is never stored, so the walk starts at 1 and ends on NREGS-1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) state_d = RF_READY;
      end
      RF_READY: begin
        if (clr_req_i) begin
          state_d = RF_INIT;
          idx_d   = AW'(1);
        end
      end
      default: state_d = RF_INIT;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == RF_READY);
    scrub_we_o  = (state_q == RF_INIT);
    scrub_idx_o = idx_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD-read / 2-write register file with bypass and issue scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = rf_addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [XLEN-1:0]   wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [XLEN-1:0]   wr1_data,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_addr
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             scrub_we;
  logic [AW-1:0]    scrub_idx;
  logic             w0_act, w1_act, sb_act;

  rf_scrub_ctrl #(.NREGS(NREGS)) u_scrub (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_req_i   (clr_req),
    .ready_o     (ready),
    .scrub_we_o  (scrub_we),
    .scrub_idx_o (scrub_idx)
  );

  // A clear request discards everything else issued in the same cycle.
  assign w0_act = ready && !clr_req && wr0_en && (wr0_addr != '0);
  assign w1_act = ready && !clr_req && wr1_en && (wr1_addr != '0);
  assign sb_act = ready && !clr_req && sb_set_en && (sb_set_addr != '0);

  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[scrub_idx] <= '0;
    end else begin
      if (w0_act) mem[wr0_addr] <= wr0_data;
      if (w1_act) mem[wr1_addr] <= wr1_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (!ready || clr_req) begin
      busy_d = '0;
    end else begin
      if (w0_act) busy_d[wr0_addr] = 1'b0;
      if (w1_act) busy_d[wr1_addr] = 1'b0;
      if (sb_act) busy_d[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit0, hit1;
    logic [XLEN-1:0] rdat;

    assign ra   = rd_addr[k*AW +: AW];
    assign hit1 = (BYPASS != 0) && w1_act && (wr1_addr == ra);
    assign hit0 = (BYPASS != 0) && w0_act && (wr0_addr == ra);

    always_comb begin
      if (!ready || ra == '0) rdat = '0;
      else if (hit1)          rdat = wr1_data;
      else if (hit0)          rdat = wr0_data;
      else                    rdat = mem[ra];
    end

    assign rd_data[k*XLEN +: XLEN] = rdat;
    assign rd_busy[k] = ready && busy_q[ra] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed bench for regfile_mp, bypass and non-bypass instances side by side
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clr_req;
  logic [NRD*AW-1:0] rd_addr;
  logic              wr0_en, wr1_en, sb_set_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, sb_set_addr;
  logic [XLEN-1:0]   wr0_data, wr1_data;

  logic                ready_b1, ready_b0;
  logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
  logic [NRD-1:0]      rd_busy_b1, rd_busy_b0;
  logic [XLEN-1:0]     d0_b1, d1_b1, d0_b0, d1_b0;

  assign d0_b1 = rd_data_b1[31:0];
  assign d1_b1 = rd_data_b1[63:32];
  assign d0_b0 = rd_data_b0[31:0];
  assign d1_b0 = rd_data_b0[63:32];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b1),
    .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_dut_b0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b0),
    .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wr0_en = 1'b0; wr1_en = 1'b0; sb_set_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr0(input int a, input logic [31:0] d);
    wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [31:0] d);
    wr1_en = 1'b1; wr1_addr = AW'(a); wr1_data = d;
  endtask

  task automatic sb(input int a);
    sb_set_en = 1'b1; sb_set_addr = AW'(a);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    rd_addr = '0; wr0_addr = '0; wr1_addr = '0; sb_set_addr = '0;
    wr0_data = '0; wr1_data = '0;
    repeat (3) tick();
    chk("rst_ready_b1", ready_b1, 0);
    chk("rst_ready_b0", ready_b0, 0);
    chk("rst_busy", rd_busy_b1, 0);

    rst = 1'b1;
    wait_ready(cnt);
    chk("scrub_len", cnt, 31);
    chk("ready_b0", ready_b0, 1);

    for (int r = 1; r < NREGS; r++) begin
      wr0(r, 32'hBAD0_0000 | r);
      tick();
    end
    quiet();
    set_rd(17, 31);
    #2;
    chk("garbage_x17", d0_b0, 32'hBAD0_0011);
    chk("garbage_x31", d1_b0, 32'hBAD0_001F);

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    chk("clr_ready_drop", ready_b1, 0);
    chk("init_rd_zero", d0_b1, 0);
    wait_ready(cnt);
    chk("clr_scrub_len", cnt, 31);
    for (int r = 0; r < NREGS; r++) begin
      set_rd(r, r);
      #1;
      chk($sformatf("scrub_b1_x%0d", r), d0_b1, 0);
      chk($sformatf("scrub_b0_x%0d", r), d1_b0, 0);
    end

    wr0(5, 32'hDEAD_BEEF);
    tick();
    quiet();
    set_rd(5, 0);
    #2;
    chk("x5_p0_b1", d0_b1, 32'hDEAD_BEEF);
    chk("x0_p1_b1", d1_b1, 0);
    chk("x5_p0_b0", d0_b0, 32'hDEAD_BEEF);

    wr0(0, 32'h1234);
    set_rd(0, 0);
    #2;
    chk("x0_bypass", d0_b1, 0);
    tick();
    quiet();
    #2;
    chk("x0_read_b1", d0_b1, 0);
    chk("x0_read_b0", d0_b0, 0);

    wr0(7, 32'h11);
    wr1(7, 32'h22);
    set_rd(7, 8);
    #2;
    chk("coll_byp_b1", d0_b1, 32'h22);
    chk("coll_nobyp_b0", d0_b0, 0);
    tick();
    quiet();
    #2;
    chk("coll_after_b1", d0_b1, 32'h22);
    chk("coll_after_b0", d0_b0, 32'h22);

    wr0(8, 32'h33);
    #2;
    chk("wr0_byp_b1", d1_b1, 32'h33);
    chk("wr0_nobyp_b0", d1_b0, 0);
    tick();
    quiet();

    sb(9);
    set_rd(9, 0);
    #2;
    chk("sb_same_cycle", rd_busy_b1[0], 0);
    tick();
    quiet();
    #2;
    chk("sb_busy_b1", rd_busy_b1[0], 1);
    chk("sb_busy_b0", rd_busy_b0[0], 1);

    wr0(9, 32'h1);
    sb(9);
    #2;
    chk("sb_wr_byp_b1", rd_busy_b1[0], 0);
    chk("sb_wr_nobyp_b0", rd_busy_b0[0], 1);
    tick();
    quiet();
    #2;
    chk("sb_wins_b1", rd_busy_b1[0], 1);
    chk("sb_wins_b0", rd_busy_b0[0], 1);

    wr1(9, 32'h2);
    #2;
    chk("wr1_clr_byp_b1", rd_busy_b1[0], 0);
    chk("wr1_clr_nobyp_b0", rd_busy_b0[0], 1);
    tick();
    quiet();
    #2;
    chk("wr1_clr_after_b1", rd_busy_b1[0], 0);
    chk("wr1_clr_after_b0", rd_busy_b0[0], 0);
    chk("x9_data_b0", d0_b0, 32'h2);

    sb(0);
    tick();
    quiet();
    set_rd(0, 0);
    #2;
    chk("sb_x0", rd_busy_b1, 0);

    sb(10);
    tick();
    tick();
    quiet();
    set_rd(10, 10);
    #2;
    chk("sb_twice_b1", rd_busy_b1, 2'b11);
    chk("sb_twice_b0", rd_busy_b0, 2'b11);

    wr0(3, 32'hA5);
    tick();
    quiet();
    clr_req = 1'b1;
    wr0(4, 32'h77);
    sb(4);
    set_rd(3, 4);
    #2;
    chk("clr_cycle_x3", d0_b1, 32'hA5);
    chk("clr_cycle_x4_drop", d1_b1, 0);
    tick();
    quiet();
    #2;
    chk("clr_ready_b1", ready_b1, 0);
    chk("clr_init_rd", d0_b1, 0);
    chk("clr_init_busy", rd_busy_b1, 0);

    repeat (9) tick();
    chk("mid_scrub_ready", ready_b1, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", ready_b1, 0);
    tick();
    rst = 1'b1;
    wait_ready(cnt);
    chk("restart_len", cnt, 31);
    set_rd(3, 4);
    #2;
    chk("after_x3", d0_b1, 0);
    chk("after_x4", d1_b0, 0);
    chk("after_busy34", rd_busy_b1, 0);
    set_rd(10, 5);
    #2;
    chk("after_busy10", rd_busy_b0[0], 0);
    chk("after_x5", d1_b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write core register file. Provides NRD combinational read ports and two prioritised write ports, with optional same-cycle write-to-read bypass. A per-register scoreboard (busy bits) supports issue stalling. A scrub FSM zeroes the array after reset or on request, so the storage itself needs no reset. Sits between decode (reads, scoreboard set) and writeback (two retire lanes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=4); register 0 hardwired to zero
NRD, 2, number of read ports
BYPASS, 1, 1 = a read hitting a same-cycle write returns the write data; 0 = it returns stored data

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr_req  in  1  request array scrub (level, sampled in READY only)
ready  out  1  1 = array valid, ports active
rd_addr  in  NRD*AW  read addresses, AW = $clog2(NREGS), port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NRD  scoreboard busy flag per read port
wr0_en  in  1  write port 0 enable
wr0_addr  in  AW  write port 0 address
wr0_data  in  XLEN  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  AW  write port 1 address
wr1_data  in  XLEN  write port 1 data
sb_set_en  in  1  mark destination pending
sb_set_addr  in  AW  destination to mark

Behaviour:
- Reset (rst=0, async): state=INIT, scrub_idx=1, all busy bits=0, ready=0. Array contents are not reset.
- INIT: each rising edge writes 0 to array[scrub_idx] and increments scrub_idx. The edge that writes NREGS-1 moves to READY; ready=1 from that edge onward. ready therefore rises NREGS-1 edges after rst release (31 at default).
- In INIT, wr*/sb_set are ignored, rd_data=0, rd_busy=0.
- READY + clr_req=1: next edge goes to INIT with scrub_idx=1 and all busy bits cleared. Writes and sb_set in that same cycle are dropped.
- Reset asserted mid-scrub: restarts INIT from index 1 immediately.
- Register 0: reads always 0, writes dropped, busy never set, rd_busy always 0.
- Writes: registered on the rising edge. Visible through the array on the next cycle.
- Write collision: wr0 and wr1 to the same address in the same cycle -> wr1 data stored.
- Write to address A clears busy[A] on that edge.
- sb_set to A in the same cycle as a write to A -> busy[A]=1 (the new producer wins).
- Read, BYPASS=1: if wr1 hits rd_addr (nonzero), return wr1_data; else if wr0 hits, return wr0_data; else return array. rd_busy = busy[addr] && !(any write to addr this cycle).
- Read, BYPASS=0: rd_data = array[addr]; rd_busy = busy[addr].
- sb_set to a busy register: stays 1, no error.
- All read outputs are purely combinational from addresses and state; no read latency.

Decomposition:
- Package regfile_pkg: typedef enum logic {RF_INIT, RF_READY} rf_state_t; localparam helper for AW. XLEN/NREGS defaults live there as constants.
- Sub-module rf_scrub_ctrl: state register, scrub_idx counter, clr_req handling. Outputs ready, scrub_we, scrub_idx.
- The array, write arbitration, bypass muxing and scoreboard stay in regfile_mp.

Test Plan:
- Reset release, no activity -> ready low for 31 edges, high after edge 31; every register reads 0 (prefill the array with X/garbage in the bench).
- READY: wr0 x5=0xDEADBEEF, then read x5 on port 0 and x0 on port 1 -> 0xDEADBEEF and 0. Write x0=0x1234, then read x0 -> 0.
- Same cycle: wr0 x7=0x11, wr1 x7=0x22; BYPASS=1, port 0 reads x7 -> 0x22 that cycle and after.
- Same test with BYPASS=0 -> port 0 reads old value that cycle, 0x22 the next.
- sb_set x9, next cycle rd_busy=1 on x9. Then wr0 x9 plus sb_set x9 together -> busy stays 1. Then wr1 x9 alone -> rd_busy=0 during that cycle (BYPASS=1) and after.
- clr_req after writing x3=0xA5 -> ready drops next edge, rd_data=0 during INIT, x3 reads 0 after ready returns. Asserting rst at scrub_idx=10 -> ready stays 0 and a full 31-edge scrub restarts.
